// File: rtl/picosoc_bus_pkg.sv
// Shared types and default constants for the PicoRV32 native-bus fabric.
//   bus_state_e     : fabric FSM states
//   DEF_ERR_RDATA   : read data returned on an unmapped or timed-out access
//   DEF_BASE_ADDRS  : default slave bases, slave i at [32*i+:32]
//                     (0: RAM, 1: progmem, 2: UART, 3: iomem)
//   DEF_ADDR_MASKS  : default slave masks, same packing
package picosoc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  localparam logic [31:0]  DEF_ERR_RDATA  = 32'hDEAD_BEEF;
  localparam logic [127:0] DEF_BASE_ADDRS = {32'h0200_0000, 32'h0100_0000,
                                             32'h0010_0000, 32'h0000_0000};
  localparam logic [127:0] DEF_ADDR_MASKS = {32'hFF00_0000, 32'hFF00_0000,
                                             32'hFFF0_0000, 32'hFFFF_FC00};

endpackage

// File: rtl/picosoc_addr_decode.sv
// Combinational address decoder for the bus fabric.
//   addr : master byte address
//   sel  : one-hot slave select (zero when unmapped); lowest index wins on overlap
module picosoc_addr_decode
  import picosoc_bus_pkg::*;
#(
  parameter int                         NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0]   BASE_ADDRS = DEF_BASE_ADDRS,
  parameter logic [NUM_SLAVES*32-1:0]   ADDR_MASKS = DEF_ADDR_MASKS
) (
  input  logic [31:0]           addr,
  output logic [NUM_SLAVES-1:0] sel
);

  logic [NUM_SLAVES-1:0] hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit[i] = (addr & ADDR_MASKS[32*i +: 32]) == BASE_ADDRS[32*i +: 32];
    end
  end

  // Isolate the lowest set bit: x & -x.
  assign sel = hit & (~hit + NUM_SLAVES'(1));

endmodule

// File: rtl/picosoc_bus_fabric.sv
// PicoRV32 native-bus router: one master fanned out to NUM_SLAVES slaves with a
// registered response, per-access timeout watchdog and bus-error reporting.
//   clk, rst                 : clock, synchronous active-high reset
//   m_valid/m_ready          : master request / one-cycle response pulse
//   m_addr/m_wdata/m_wstrb   : master address, write data, byte strobes (0 = read)
//   m_rdata                  : registered read data, valid while m_ready
//   s_valid/s_ready/s_rdata  : per-slave request, completion, read data
//   s_addr/s_wdata/s_wstrb   : broadcast copies of the master request
//   irq_bus_err              : one-cycle pulse with the m_ready of a failed access
//   err_addr/err_count       : last failing address, saturating failure count
//
// state  | meaning
// IDLE   | waiting for m_valid; decodes and presents s_valid combinationally
// ACCESS | selected slave has not answered yet; watchdog counting
// RESP   | m_ready pulse with captured (or error) read data
module picosoc_bus_fabric
  import picosoc_bus_pkg::*;
#(
  parameter int                       NUM_SLAVES     = 4,
  parameter int                       DATA_W         = 32,
  parameter logic [NUM_SLAVES*32-1:0] BASE_ADDRS     = DEF_BASE_ADDRS,
  parameter logic [NUM_SLAVES*32-1:0] ADDR_MASKS     = DEF_ADDR_MASKS,
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]        ERR_RDATA      = DATA_W'(DEF_ERR_RDATA)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_valid,
  output logic                         m_ready,
  input  logic [31:0]                  m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W/8-1:0]          m_wstrb,
  output logic [DATA_W-1:0]            m_rdata,
  output logic [NUM_SLAVES-1:0]        s_valid,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  output logic [31:0]                  s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wstrb,
  output logic                         irq_bus_err,
  output logic [31:0]                  err_addr,
  output logic [15:0]                  err_count
);

  localparam int              CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  bus_state_e            state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  m_ready_q, m_ready_d;
  logic                  irq_q, irq_d;
  logic [31:0]           err_addr_q, err_addr_d;
  logic [15:0]           err_count_q, err_count_d;

  logic [NUM_SLAVES-1:0] sel, cur_sel, s_valid_c;
  logic [DATA_W-1:0]     slave_rdata;
  logic                  slave_ready;
  logic                  bus_err;

  picosoc_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDRS (BASE_ADDRS),
    .ADDR_MASKS (ADDR_MASKS)
  ) u_decode (
    .addr (m_addr),
    .sel  (sel)
  );

  // In IDLE the live decode selects the slave; afterwards the latched one does,
  // so ready/rdata from any other slave never reaches the master.
  assign cur_sel = (state_q == ST_IDLE) ? sel : sel_q;

  always_comb begin
    slave_rdata = '0;
    slave_ready = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (cur_sel[i]) begin
        slave_rdata = slave_rdata | s_rdata[DATA_W*i +: DATA_W];
        slave_ready = slave_ready | s_ready[i];
      end
    end
  end

  // Counter holds at the limit instead of wrapping.
  assign cnt_inc = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    m_ready_d   = 1'b0;
    irq_d       = 1'b0;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    s_valid_c   = '0;
    bus_err     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m_valid) begin
          if (|sel) begin
            s_valid_c = sel;
            sel_d     = sel;
            cnt_d     = '0;
            if (slave_ready) begin
              state_d   = ST_RESP;
              rdata_d   = slave_rdata;
              m_ready_d = 1'b1;
            end else begin
              state_d = ST_ACCESS;
            end
          end else begin
            bus_err = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (!m_valid) begin
          // Master abandoned the request: drop it silently.
          state_d = ST_IDLE;
        end else begin
          s_valid_c = sel_q;
          cnt_d     = cnt_inc;
          // The incremented count is the number of ACCESS cycles spent,
          // so the error fires at the end of the TIMEOUT_CYCLES-th one.
          if (slave_ready) begin
            state_d   = ST_RESP;
            rdata_d   = slave_rdata;
            m_ready_d = 1'b1;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_LIMIT)) begin
            bus_err = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus_err) begin
      state_d    = ST_RESP;
      m_ready_d  = 1'b1;
      irq_d      = 1'b1;
      rdata_d    = ERR_RDATA;
      err_addr_d = m_addr;
      if (err_count_q != 16'hFFFF) begin
        err_count_d = err_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      m_ready_q   <= 1'b0;
      irq_q       <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      m_ready_q   <= m_ready_d;
      irq_q       <= irq_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign s_valid     = rst ? '0 : s_valid_c;
  assign s_addr      = m_addr;
  assign s_wdata     = m_wdata;
  assign s_wstrb     = m_wstrb;
  assign m_ready     = m_ready_q;
  assign m_rdata     = rdata_q;
  assign irq_bus_err = irq_q;
  assign err_addr    = err_addr_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_picosoc_bus_fabric.sv
// Directed bench for picosoc_bus_fabric. Slave 2 is remapped to base 0 with an
// 16 MiB mask so that it overlaps slave 0 (and slave 1); TIMEOUT_CYCLES is 8.
module tb_picosoc_bus_fabric;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [3:0]   m_wstrb;
  logic [31:0]  m_rdata;
  logic [3:0]   s_valid;
  logic [3:0]   s_ready;
  logic [127:0] s_rdata;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic         irq_bus_err;
  logic [31:0]  err_addr;
  logic [15:0]  err_count;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  picosoc_bus_fabric #(
    .NUM_SLAVES     (4),
    .DATA_W         (32),
    .BASE_ADDRS     ({32'h0200_0000, 32'h0000_0000, 32'h0010_0000, 32'h0000_0000}),
    .ADDR_MASKS     ({32'hFF00_0000, 32'hFF00_0000, 32'hFFF0_0000, 32'hFFFF_FC00}),
    .TIMEOUT_CYCLES (8),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_rdata     (m_rdata),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_rdata     (s_rdata),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .irq_bus_err (irq_bus_err),
    .err_addr    (err_addr),
    .err_count   (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    m_valid = 1'b1;
    m_addr  = a;
    m_wdata = wd;
    m_wstrb = ws;
  endtask

  task automatic drop();
    m_valid = 1'b0;
    s_ready = 4'b0000;
  endtask

  initial begin
    rst     = 1'b1;
    m_valid = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    s_ready = '0;
    s_rdata = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset state; s_valid gated even with a mapped request pending.
    req(32'h0000_0010, 32'h0, 4'h0);
    #1;
    chk("rst_svalid", {28'h0, s_valid}, 32'h0);
    chk("rst_mready", {31'h0, m_ready}, 32'h0);
    chk("rst_irq", {31'h0, irq_bus_err}, 32'h0);
    chk("rst_rdata", m_rdata, 32'h0);
    chk("rst_erraddr", err_addr, 32'h0);
    chk("rst_errcnt", {16'h0, err_count}, 32'h0);
    @(negedge clk);
    drop();
    rst = 1'b0;
    @(negedge clk);

    // 1: read slave 0, ready one cycle after s_valid (slave 2 also hits).
    req(32'h0000_0010, 32'h0, 4'h0);
    #1 chk("t1_svalid", {28'h0, s_valid}, 32'h1);
    @(negedge clk);
    chk("t1_wait_mready", {31'h0, m_ready}, 32'h0);
    chk("t1_wait_svalid", {28'h0, s_valid}, 32'h1);
    s_ready = 4'b0001;
    s_rdata[31:0] = 32'h1234_5678;
    @(negedge clk);
    chk("t1_mready", {31'h0, m_ready}, 32'h1);
    chk("t1_rdata", m_rdata, 32'h1234_5678);
    chk("t1_irq", {31'h0, irq_bus_err}, 32'h0);
    drop();
    @(negedge clk);
    chk("t1_idle_mready", {31'h0, m_ready}, 32'h0);

    // 2: zero-wait write to slave 3.
    req(32'h0200_0004, 32'hCAFE_F00D, 4'hF);
    s_ready = 4'b1000;
    #1;
    chk("t2_svalid", {28'h0, s_valid}, 32'h8);
    chk("t2_swstrb", {28'h0, s_wstrb}, 32'hF);
    chk("t2_saddr", s_addr, 32'h0200_0004);
    chk("t2_swdata", s_wdata, 32'hCAFE_F00D);
    @(negedge clk);
    chk("t2_mready", {31'h0, m_ready}, 32'h1);
    chk("t2_svalid_resp", {28'h0, s_valid}, 32'h0);
    drop();
    @(negedge clk);

    // 3: unmapped read.
    req(32'h0300_0000, 32'h0, 4'h0);
    #1 chk("t3_svalid", {28'h0, s_valid}, 32'h0);
    @(negedge clk);
    chk("t3_mready", {31'h0, m_ready}, 32'h1);
    chk("t3_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("t3_irq", {31'h0, irq_bus_err}, 32'h1);
    chk("t3_erraddr", err_addr, 32'h0300_0000);
    chk("t3_errcnt", {16'h0, err_count}, 32'd1);
    drop();
    @(negedge clk);
    chk("t3_irq_pulse", {31'h0, irq_bus_err}, 32'h0);

    // 4: slave 1 never ready (slave 0 ready must be ignored); timeout after 8 ACCESS cycles.
    req(32'h0010_0000, 32'h0, 4'h0);
    s_ready = 4'b0001;
    #1 chk("t4_svalid", {28'h0, s_valid}, 32'h2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!m_ready && n == 8) chk("t4_svalid_late", {28'h0, s_valid}, 32'h2);
    end while (!m_ready && n < 20);
    chk("t4_latency", n, 32'd9);
    chk("t4_svalid_drop", {28'h0, s_valid}, 32'h0);
    chk("t4_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("t4_irq", {31'h0, irq_bus_err}, 32'h1);
    chk("t4_erraddr", err_addr, 32'h0010_0000);
    chk("t4_errcnt", {16'h0, err_count}, 32'd2);
    drop();
    @(negedge clk);

    // 5: overlap -> slave 0 only; slave 2 ready ignored.
    req(32'h0000_0020, 32'h0, 4'h0);
    s_ready = 4'b0100;
    s_rdata[95:64] = 32'hBBBB_BBBB;
    #1 chk("t5_svalid", {28'h0, s_valid}, 32'h1);
    @(negedge clk);
    chk("t5_ignored", {31'h0, m_ready}, 32'h0);
    s_ready = 4'b0001;
    s_rdata[31:0] = 32'hA5A5_0001;
    @(negedge clk);
    chk("t5_mready", {31'h0, m_ready}, 32'h1);
    chk("t5_rdata", m_rdata, 32'hA5A5_0001);
    drop();
    @(negedge clk);

    // Slave 2 on its own (above slave 0's 1 KiB window), zero wait.
    req(32'h0000_0400, 32'h0, 4'h0);
    s_ready = 4'b0100;
    s_rdata[95:64] = 32'h2222_0400;
    #1 chk("s2_svalid", {28'h0, s_valid}, 32'h4);
    @(negedge clk);
    chk("s2_rdata", m_rdata, 32'h2222_0400);
    drop();
    @(negedge clk);

    // s_ready in the same cycle the watchdog expires: ready wins.
    req(32'h0010_0008, 32'h0, 4'h0);
    for (int i = 0; i < 8; i++) @(negedge clk);
    chk("race_wait", {31'h0, m_ready}, 32'h0);
    s_ready = 4'b0010;
    s_rdata[63:32] = 32'h1111_0008;
    @(negedge clk);
    chk("race_mready", {31'h0, m_ready}, 32'h1);
    chk("race_rdata", m_rdata, 32'h1111_0008);
    chk("race_irq", {31'h0, irq_bus_err}, 32'h0);
    chk("race_errcnt", {16'h0, err_count}, 32'd2);
    drop();
    @(negedge clk);

    // Master drops m_valid during ACCESS: no response, no error.
    req(32'h0010_0000, 32'h0, 4'h0);
    @(negedge clk);
    drop();
    @(negedge clk);
    chk("abort_mready", {31'h0, m_ready}, 32'h0);
    @(negedge clk);
    chk("abort_mready2", {31'h0, m_ready}, 32'h0);
    chk("abort_errcnt", {16'h0, err_count}, 32'd2);

    // 6: reset during ACCESS.
    req(32'h0010_0000, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("t6_svalid", {28'h0, s_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drop();
    #1;
    chk("t6_mready", {31'h0, m_ready}, 32'h0);
    chk("t6_errcnt", {16'h0, err_count}, 32'h0);
    @(negedge clk);
    chk("t6_mready2", {31'h0, m_ready}, 32'h0);

    // Error count saturation.
    force dut.err_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.err_count_q;
    @(negedge clk);
    chk("sat_preset", {16'h0, err_count}, 32'h0000_FFFE);
    req(32'h0400_0000, 32'h0, 4'h0);
    @(negedge clk);
    chk("sat_cnt1", {16'h0, err_count}, 32'h0000_FFFF);
    drop();
    @(negedge clk);
    req(32'h0500_0000, 32'h0, 4'h0);
    @(negedge clk);
    chk("sat_cnt2", {16'h0, err_count}, 32'h0000_FFFF);
    chk("sat_irq", {31'h0, irq_bus_err}, 32'h1);
    chk("sat_erraddr", err_addr, 32'h0500_0000);
    drop();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
